uart_serial_bridge: RTL and testbench

//  Bridges the processor's byte-wide serial IO ports to a physical 8N1 UART line pair.
//  RX side: deserialises uart_rx_in into a receive FIFO, which drives serial_in / serial_valid_in.
//  TX side: accepts serial_out bytes on serial_wren_out into a transmit FIFO, then serialises them onto uart_tx_out.

---
 rtl/uart_serial_bridge_if.sv | 28 ++
 rtl/uart_serial_bridge.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_serial_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_serial_bridge_if.sv
// Processor-side byte port of the UART bridge: RX FIFO head/pop and TX FIFO push/ready.
// The bridge is the slave; the processor (or a bench standing in for it) is the master.
interface uart_serial_bridge_if;
   logic [7:0] rx_data_out;
   logic       rx_valid_out;
   logic       rx_rden_in;
   logic [7:0] tx_data_in;
   logic       tx_wren_in;
   logic       tx_ready_out;

   modport slave (
      output rx_data_out,
      output rx_valid_out,
      output tx_ready_out,
      input  rx_rden_in,
      input  tx_data_in,
      input  tx_wren_in
   );

   modport master (
      input  rx_data_out,
      input  rx_valid_out,
      input  tx_ready_out,
      output rx_rden_in,
      output tx_data_in,
      output tx_wren_in
   );
endinterface

// File: rtl/uart_serial_bridge.sv
// 8N1 UART bridge: a synchronised RX deserialiser feeding a fall-through FIFO, and a TX
// FIFO feeding a serialiser, both exposed to the processor through uart_serial_bridge_if.
module uart_serial_bridge #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_AW      = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  uart_rx_in,
   output logic                  uart_tx_out,
   output logic                  rx_overrun_out,
   output logic                  rx_frame_err_out,
   uart_serial_bridge_if.slave   proc
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]      BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]      HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]      TMR_ONE   = TW'(1'b1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1'b1);
   localparam logic [CW-1:0]      FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0]      ZERO_CNT  = {CW{1'b0}};

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

   // ---------------- RX path ----------------
   logic [1:0]         rx_sync_r;
   logic               rx_line_s;
   uart_state_t        rx_state_r, rx_state_nx_s;
   logic [TW-1:0]      rx_timer_r;
   logic [2:0]         rx_bit_idx_r;
   logic [7:0]         rx_shift_r;
   logic               rx_timer_clr_s, rx_sample_s, rx_stop_s, rx_push_req_s, rx_ferr_set_s;
   logic [7:0]         rx_mem_r [DEPTH];
   logic [FIFO_AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r, rx_rd_nx_s;
   logic [CW-1:0]      rx_count_r, rx_count_nx_s;
   logic               rx_full_s, rx_push_s, rx_pop_s, rx_ovr_set_s;
   logic [7:0]         rx_head_nx_s;
   logic [7:0]         rx_data_r;
   logic               rx_valid_r, rx_overrun_r, rx_frame_err_r;

   // Two-flop synchroniser for the asynchronous line; resets to idle-high
   always_ff @(posedge clock) begin
      if (reset) rx_sync_r <= 2'b11;
      else       rx_sync_r <= {rx_sync_r[0], uart_rx_in};
   end

   assign rx_line_s = rx_sync_r[1];

   // RX state register
   always_ff @(posedge clock) begin
      if (reset) rx_state_r <= ST_IDLE;
      else       rx_state_r <= rx_state_nx_s;
   end

   // RX next-state: start bit is re-checked at half a bit to reject glitches
   always_comb begin
      rx_state_nx_s = rx_state_r;
      case (rx_state_r)
         ST_IDLE: begin
            if (!rx_line_s) rx_state_nx_s = ST_START;
            else            rx_state_nx_s = ST_IDLE;
         end
         ST_START: begin
            if (rx_timer_r == HALF_LAST) rx_state_nx_s = rx_line_s ? ST_IDLE : ST_DATA;
            else                         rx_state_nx_s = ST_START;
         end
         ST_DATA: begin
            if ((rx_timer_r == BIT_LAST) && (rx_bit_idx_r == 3'd7)) rx_state_nx_s = ST_STOP;
            else                                                    rx_state_nx_s = ST_DATA;
         end
         ST_STOP: begin
            if (rx_timer_r == BIT_LAST) rx_state_nx_s = ST_IDLE;
            else                        rx_state_nx_s = ST_STOP;
         end
         default: rx_state_nx_s = ST_IDLE;
      endcase
   end

   // RX control outputs
   always_comb begin
      rx_timer_clr_s = (rx_state_r == ST_IDLE) || (rx_state_nx_s != rx_state_r);
      rx_sample_s    = (rx_state_r == ST_DATA) && (rx_timer_r == BIT_LAST);
      rx_stop_s      = (rx_state_r == ST_STOP) && (rx_timer_r == BIT_LAST);
      rx_push_req_s  = rx_stop_s && rx_line_s;
      rx_ferr_set_s  = rx_stop_s && !rx_line_s;
   end

   // RX bit timer, bit index and LSB-first shift register
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_timer_r   <= {TW{1'b0}};
         rx_bit_idx_r <= 3'd0;
         rx_shift_r   <= 8'h00;
      end else begin
         if (rx_timer_clr_s || (rx_timer_r == BIT_LAST)) rx_timer_r <= {TW{1'b0}};
         else                                            rx_timer_r <= rx_timer_r + TMR_ONE;
         if (rx_state_r != ST_DATA) rx_bit_idx_r <= 3'd0;
         else if (rx_sample_s)      rx_bit_idx_r <= rx_bit_idx_r + 3'd1;
         if (rx_sample_s) rx_shift_r <= {rx_line_s, rx_shift_r[7:1]};
      end
   end

   // RX FIFO control; a full FIFO still accepts a push when it is popped in the same cycle
   always_comb begin
      rx_full_s     = (rx_count_r == FULL_CNT);
      rx_pop_s      = proc.rx_rden_in && (rx_count_r != ZERO_CNT);
      rx_push_s     = rx_push_req_s && (!rx_full_s || rx_pop_s);
      rx_ovr_set_s  = rx_push_req_s && rx_full_s && !rx_pop_s;
      rx_count_nx_s = rx_count_r + CW'(rx_push_s) - CW'(rx_pop_s);
      rx_rd_nx_s    = rx_pop_s ? (rx_rd_ptr_r + PTR_ONE) : rx_rd_ptr_r;
      // The new head is the byte being written when it lands in the slot the head moves to
      if (rx_push_s && (rx_wr_ptr_r == rx_rd_nx_s)) rx_head_nx_s = rx_shift_r;
      else                                          rx_head_nx_s = rx_mem_r[rx_rd_nx_s];
   end

   // RX FIFO storage
   always_ff @(posedge clock) begin
      if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
   end

   // RX FIFO pointers, registered head/valid and sticky error flags
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_wr_ptr_r    <= {FIFO_AW{1'b0}};
         rx_rd_ptr_r    <= {FIFO_AW{1'b0}};
         rx_count_r     <= ZERO_CNT;
         rx_data_r      <= 8'h00;
         rx_valid_r     <= 1'b0;
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
      end else begin
         if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
         rx_rd_ptr_r    <= rx_rd_nx_s;
         rx_count_r     <= rx_count_nx_s;
         rx_valid_r     <= (rx_count_nx_s != ZERO_CNT);
         rx_data_r      <= (rx_count_nx_s != ZERO_CNT) ? rx_head_nx_s : 8'h00;
         rx_overrun_r   <= rx_overrun_r | rx_ovr_set_s;
         rx_frame_err_r <= rx_frame_err_r | rx_ferr_set_s;
      end
   end

   // ---------------- TX path ----------------
   uart_state_t        tx_state_r, tx_state_nx_s;
   logic [TW-1:0]      tx_timer_r;
   logic [2:0]         tx_bit_idx_r;
   logic [7:0]         tx_shift_r;
   logic               tx_line_s, tx_timer_clr_s, tx_shift_en_s;
   logic [7:0]         tx_mem_r [DEPTH];
   logic [FIFO_AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
   logic [CW-1:0]      tx_count_r, tx_count_nx_s;
   logic               tx_push_s, tx_pop_s;
   logic               tx_ready_r, uart_tx_r;

   // TX FIFO control; ready is registered so a write never lands in a full FIFO
   always_comb begin
      tx_push_s     = proc.tx_wren_in && tx_ready_r;
      tx_pop_s      = (tx_state_r == ST_IDLE) && (tx_count_r != ZERO_CNT);
      tx_count_nx_s = tx_count_r + CW'(tx_push_s) - CW'(tx_pop_s);
   end

   // TX FIFO storage
   always_ff @(posedge clock) begin
      if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= proc.tx_data_in;
   end

   // TX FIFO pointers and ready flag
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_wr_ptr_r <= {FIFO_AW{1'b0}};
         tx_rd_ptr_r <= {FIFO_AW{1'b0}};
         tx_count_r  <= ZERO_CNT;
         tx_ready_r  <= 1'b1;
      end else begin
         if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
         if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
         tx_count_r <= tx_count_nx_s;
         tx_ready_r <= (tx_count_nx_s != FULL_CNT);
      end
   end

   // TX state register
   always_ff @(posedge clock) begin
      if (reset) tx_state_r <= ST_IDLE;
      else       tx_state_r <= tx_state_nx_s;
   end

   // TX next-state: one IDLE cycle separates back-to-back frames
   always_comb begin
      tx_state_nx_s = tx_state_r;
      case (tx_state_r)
         ST_IDLE: begin
            if (tx_count_r != ZERO_CNT) tx_state_nx_s = ST_START;
            else                        tx_state_nx_s = ST_IDLE;
         end
         ST_START: begin
            if (tx_timer_r == BIT_LAST) tx_state_nx_s = ST_DATA;
            else                        tx_state_nx_s = ST_START;
         end
         ST_DATA: begin
            if ((tx_timer_r == BIT_LAST) && (tx_bit_idx_r == 3'd7)) tx_state_nx_s = ST_STOP;
            else                                                    tx_state_nx_s = ST_DATA;
         end
         ST_STOP: begin
            if (tx_timer_r == BIT_LAST) tx_state_nx_s = ST_IDLE;
            else                        tx_state_nx_s = ST_STOP;
         end
         default: tx_state_nx_s = ST_IDLE;
      endcase
   end

   // TX outputs: line level per state and shift strobe at the end of each data bit
   always_comb begin
      tx_timer_clr_s = (tx_state_r == ST_IDLE);
      tx_shift_en_s  = (tx_state_r == ST_DATA) && (tx_timer_r == BIT_LAST);
      case (tx_state_r)
         ST_IDLE:  tx_line_s = 1'b1;
         ST_START: tx_line_s = 1'b0;
         ST_DATA:  tx_line_s = tx_shift_r[0];
         ST_STOP:  tx_line_s = 1'b1;
         default:  tx_line_s = 1'b1;
      endcase
   end

   // TX bit timer, bit index, shift register and registered line output
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_timer_r   <= {TW{1'b0}};
         tx_bit_idx_r <= 3'd0;
         tx_shift_r   <= 8'h00;
         uart_tx_r    <= 1'b1;
      end else begin
         if (tx_timer_clr_s || (tx_timer_r == BIT_LAST)) tx_timer_r <= {TW{1'b0}};
         else                                            tx_timer_r <= tx_timer_r + TMR_ONE;
         if (tx_state_r != ST_DATA) tx_bit_idx_r <= 3'd0;
         else if (tx_shift_en_s)    tx_bit_idx_r <= tx_bit_idx_r + 3'd1;
         if (tx_pop_s)           tx_shift_r <= tx_mem_r[tx_rd_ptr_r];
         else if (tx_shift_en_s) tx_shift_r <= {1'b0, tx_shift_r[7:1]};
         uart_tx_r <= tx_line_s;
      end
   end

   assign uart_tx_out       = uart_tx_r;
   assign rx_overrun_out    = rx_overrun_r;
   assign rx_frame_err_out  = rx_frame_err_r;
   assign proc.rx_data_out  = rx_data_r;
   assign proc.rx_valid_out = rx_valid_r;
   assign proc.tx_ready_out = tx_ready_r;

endmodule

// File: tb/tb_uart_serial_bridge.sv
// Scoreboard bench for uart_serial_bridge: RX bytes and TX bytes are queued as expected
// values when driven and compared when the bridge delivers them.
module tb_uart_serial_bridge;
   localparam int CPB = 16;

   logic clock = 1'b0;
   logic reset;
   logic uart_rx_in;
   logic uart_tx_out;
   logic rx_overrun_out;
   logic rx_frame_err_out;

   uart_serial_bridge_if bus ();

   uart_serial_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .clock            (clock),
      .reset            (reset),
      .uart_rx_in       (uart_rx_in),
      .uart_tx_out      (uart_tx_out),
      .rx_overrun_out   (rx_overrun_out),
      .rx_frame_err_out (rx_frame_err_out),
      .proc             (bus)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] rx_exp_q[$];
   logic [7:0] tx_exp_q[$];
   int         tx_starts[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // TX line monitor: decodes each frame at bit centres and scores it against tx_exp_q
   initial begin
      logic       busy = 1'b0;
      int         t = 0;
      logic [7:0] b = 8'h00;
      forever begin
         @(negedge clock);
         if (reset === 1'b1) begin
            busy = 1'b0;
         end else if (!busy) begin
            if (uart_tx_out === 1'b0) begin
               busy = 1'b1;
               t = 0;
               tx_starts.push_back(cyc);
            end
         end else begin
            t++;
            if (t == 8) check("tx_start_bit", uart_tx_out, 0);
            else if (t >= 24 && t <= 136 && ((t - 24) % 16) == 0) b = {uart_tx_out, b[7:1]};
            else if (t == 152) begin
               check("tx_stop_bit", uart_tx_out, 1);
               if (tx_exp_q.size() == 0) check("tx_unexpected", tx_exp_q.size(), 1);
               else check("tx_byte", b, tx_exp_q.pop_front());
               busy = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic lat_chk);
      int first = -1;
      uart_rx_in = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rx_in = b[i];
         repeat (CPB) @(negedge clock);
      end
      uart_rx_in = stop_bit;
      for (int i = 0; i < CPB; i++) begin
         @(negedge clock);
         if (first < 0 && bus.rx_valid_out === 1'b1) first = i;
      end
      uart_rx_in = 1'b1;
      // i == 8 is the stop-bit midpoint
      if (lat_chk) check("rx_valid_latency", (first >= 8 && first <= 11), 1);
   endtask

   task automatic rx_pop(input string tag);
      check({tag, "_valid"}, bus.rx_valid_out, 1);
      if (rx_exp_q.size() == 0) check({tag, "_noexp"}, rx_exp_q.size(), 1);
      else check({tag, "_data"}, bus.rx_data_out, rx_exp_q.pop_front());
      bus.rx_rden_in = 1'b1;
      @(negedge clock);
      bus.rx_rden_in = 1'b0;
   endtask

   task automatic wait_tx_drain(input int budget);
      int k = 0;
      while (tx_exp_q.size() != 0 && k < budget) begin
         @(negedge clock);
         k++;
      end
      check("tx_drain", tx_exp_q.size(), 0);
   endtask

   initial begin
      int n_edge;
      int k;
      logic [7:0] d [6];

      reset = 1'b1;
      uart_rx_in = 1'b1;
      bus.rx_rden_in = 1'b0;
      bus.tx_wren_in = 1'b0;
      bus.tx_data_in = 8'h00;

      // 1: reset with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         uart_rx_in     = 1'($urandom);
         bus.rx_rden_in = 1'($urandom);
         bus.tx_wren_in = 1'($urandom);
         bus.tx_data_in = 8'($urandom);
      end
      @(negedge clock);
      check("rst_tx", uart_tx_out, 1);
      check("rst_valid", bus.rx_valid_out, 0);
      check("rst_data", bus.rx_data_out, 0);
      check("rst_ready", bus.tx_ready_out, 1);
      check("rst_ovr", rx_overrun_out, 0);
      check("rst_ferr", rx_frame_err_out, 0);
      uart_rx_in = 1'b1;
      bus.rx_rden_in = 1'b0;
      bus.tx_wren_in = 1'b0;
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // 2: single RX frame then pop
      rx_exp_q.push_back(8'hA5);
      send_rx(8'hA5, 1'b1, 1'b1);
      rx_pop("rx_a5");
      check("rx_a5_empty", bus.rx_valid_out, 0);

      // 3: single TX frame timing
      tx_starts.delete();
      bus.tx_data_in = 8'h3C;
      bus.tx_wren_in = 1'b1;
      tx_exp_q.push_back(8'h3C);
      n_edge = cyc + 1;
      @(negedge clock);
      bus.tx_wren_in = 1'b0;
      check("tx_n0_high", uart_tx_out, 1);
      @(negedge clock);
      check("tx_n1_high", uart_tx_out, 1);
      @(negedge clock);
      check("tx_n2_low", uart_tx_out, 0);
      wait_tx_drain(300);
      repeat (10) @(negedge clock);
      check("tx_idle_after", uart_tx_out, 1);
      if (tx_starts.size() == 0) check("tx_start_seen", tx_starts.size(), 1);
      else check("tx_start_cycle", tx_starts[0], n_edge + 2);

      // 4: five RX frames without popping -> overrun, four kept
      for (int i = 0; i < 5; i++) begin
         d[i] = 8'($urandom);
         if (i < 4) rx_exp_q.push_back(d[i]);
         send_rx(d[i], 1'b1, 1'b0);
      end
      repeat (4) @(negedge clock);
      check("ovr_flag", rx_overrun_out, 1);
      check("ovr_no_ferr", rx_frame_err_out, 0);
      for (int i = 0; i < 4; i++) rx_pop($sformatf("ovr_pop%0d", i));
      check("ovr_empty", bus.rx_valid_out, 0);

      do_reset(2);
      repeat (4) @(negedge clock);

      // 5: glitch, then framing error
      uart_rx_in = 1'b0;
      repeat (4) @(negedge clock);
      uart_rx_in = 1'b1;
      repeat (40) @(negedge clock);
      check("glitch_valid", bus.rx_valid_out, 0);
      check("glitch_ferr", rx_frame_err_out, 0);
      check("glitch_ovr", rx_overrun_out, 0);
      send_rx(8'h5A, 1'b0, 1'b0);
      repeat (40) @(negedge clock);
      check("ferr_flag", rx_frame_err_out, 1);
      check("ferr_valid", bus.rx_valid_out, 0);
      check("ferr_ovr", rx_overrun_out, 0);

      do_reset(2);
      repeat (4) @(negedge clock);

      // 6: six consecutive writes, fifth fills the FIFO, sixth dropped
      tx_starts.delete();
      for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("tx_ready_w%0d", i), bus.tx_ready_out, (i < 5) ? 1 : 0);
         bus.tx_data_in = d[i];
         bus.tx_wren_in = 1'b1;
         if (i < 5) tx_exp_q.push_back(d[i]);
         if (i == 0) n_edge = cyc + 1;
         @(negedge clock);
      end
      bus.tx_wren_in = 1'b0;
      wait_tx_drain(5 * 161 + 100);
      repeat (12) @(negedge clock);
      check("tx_burst_frames", tx_starts.size(), 5);
      if (tx_starts.size() == 5) begin
         check("tx_burst_first", tx_starts[0], n_edge + 2);
         for (int i = 0; i < 4; i++)
            check($sformatf("tx_spacing%0d", i), tx_starts[i + 1] - tx_starts[i], 161);
      end

      // Reset in the middle of a TX frame
      bus.tx_data_in = 8'h81;
      bus.tx_wren_in = 1'b1;
      @(negedge clock);
      bus.tx_wren_in = 1'b0;
      k = 0;
      while (uart_tx_out !== 1'b0 && k < 10) begin
         @(negedge clock);
         k++;
      end
      check("midrst_started", uart_tx_out, 0);
      repeat (40) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_tx", uart_tx_out, 1);
      check("midrst_ready", bus.tx_ready_out, 1);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      check("midrst_idle", uart_tx_out, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
